grid_cell_editor: RTL and testbench
===================================

// Module: grid_cell_editor
// PURPOSE
//  Parametrised user-edit front end for the cellular-automaton grid. It holds the ROWS x COLS seed pattern.
//  Cells are edited one per key press (toggle/set/clear), and a multi-cycle row sweep fills or clears the
//  whole grid. The grid output feeds the automaton engine's seed load and the VGA cell renderer.
// PARAMETERS
//  ROWS   16               grid rows, >=2
//  COLS   16               grid columns, >=2
//  ROW_W  $clog2(ROWS)     row index width (derived, do not override)
//  COL_W  $clog2(COLS)     column index width (derived, do not override)
// PORTS
//  clk         in   1             system clock
//  reset       in   1             synchronous, active-high reset
//  row_sel     in   ROW_W         cursor row (from row counter)
//  col_sel     in   COL_W         cursor column (from column counter)
//  key         in   1             edit key, level, high = pressed (already synchronised/debounced upstream)
//  mode        in   2             grid_pkg::mode_e: 0 TOGGLE, 1 SET, 2 CLEAR, 3 NONE
//  sweep_req   in   1             1-cycle pulse: start a full-grid sweep
//  sweep_val   in   1             value written by the sweep (0 = clear, 1 = fill); sampled with sweep_req
//  userInput   out  ROWSxCOLS     packed grid [ROWS-1:0][COLS-1:0], registered
//  cursor_cell out  1             userInput[row_sel][col_sel], combinational; 0 if cursor is out of range
//  busy        out  1             high while a sweep is in progress
//  edit_pulse  out  1             1-cycle registered strobe, high the cycle after a cell write
// BEHAVIOUR
//  Reset: userInput=0, busy=0, edit_pulse=0, key_q=0, state=IDLE, sweep row=0. Reset overrides everything, including a sweep in progress.
//  Edge detect: key_q <= key every cycle, in all states. press = key & ~key_q.
//   Exactly one write per press; holding the key causes no further writes.
//  Edit (state IDLE, press=1, no sweep_req, row_sel<ROWS, col_sel<COLS):
//   The cell written at the same clk edge is [row_sel][col_sel]:
//   TOGGLE writes ~old, SET writes 1, CLEAR writes 0, NONE makes no write.
//   Latency: key rises in cycle N, so the cell changes after the edge ending N; edit_pulse is high in N+1.
//   edit_pulse only fires when a write happens (never for NONE or out of range).
//  Out-of-range cursor: the press is dropped and no cell changes.
//  FSM states (grid_pkg::state_e): IDLE, SWEEP.
//   IDLE -> SWEEP on sweep_req: latch sweep_val, row=0.
//   SWEEP: one cycle per row; row 'row' is set to all sweep_val, then row++.
//   SWEEP -> IDLE after row ROWS-1 is written. The sweep takes exactly ROWS cycles.
//   busy = (state==SWEEP).
//  Simultaneous press and sweep_req in IDLE: the sweep wins and the press is dropped.
//  Press during SWEEP: dropped. The edge is still consumed, so no write happens after the sweep ends.
//  sweep_req during SWEEP: ignored; the sweep does not restart.
//  Arithmetic: the row counter is ROW_W bits. The terminal compare is against ROWS-1, so non-power-of-2 ROWS works.
// CONFIGURATION
//  GRID_EDITOR_UNDO_EN
//   Defined: adds input 'undo' (1-cycle pulse) and a one-deep undo register {valid, row, col, old_val}.
//    Each edit write stores the coordinates and pre-write value, then sets valid.
//    undo in IDLE with valid=1 restores the cell, clears valid and pulses edit_pulse.
//    undo with valid=0, or during SWEEP, is ignored.
//    Any sweep or reset clears valid.
//    undo together with a press in the same cycle: undo wins and the press is dropped.
//   Not defined: no undo port and no undo register; behaviour is otherwise identical.
// STRUCTURE
//  grid_pkg: mode_e enum, state_e enum, default ROWS/COLS localparams, shared by the engine and renderer.
//  Sub-module edge_rise (clk, reset, d -> q_rise): the key edge detector, reused for the step/run keys.
//  All grid writes happen in one always_ff; write-enable/data priority is computed in one always_comb:
//   reset > sweep > undo > edit.
// TESTING
//  1. reset; mode=TOGGLE; row=3 col=5; hold key high for 10 cycles -> [3][5]=1 after 1 edge, stays 1, edit_pulse exactly once.
//  2. Release, press again at [3][5] -> [3][5]=0. mode=SET pressed twice -> 1 both times. mode=CLEAR -> 0. mode=NONE -> no change, no edit_pulse.
//  3. sweep_req with sweep_val=1 -> busy high for exactly ROWS=16 cycles, rows fill 0..15 in order, grid all 1s.
//     A press mid-sweep leaves no trace.
//  4. Press and sweep_req with sweep_val=0 in the same cycle -> sweep runs and grid all 0s.
//     Assert reset at sweep row 7 -> grid 0 and busy 0 on the next cycle.
//  5. ROWS=10, COLS=12: row_sel=12 with a press -> no change; a sweep takes 10 cycles; cursor_cell=0 out of range.
//  6. UNDO_EN: toggle [2][2] to 1, then undo -> [2][2]=0; a second undo is ignored; undo after a sweep is ignored.

Source files
------------

// File: rtl/grid_cell_editor_pkg.sv
// Shared types for the cellular-automaton front end: edit modes, editor FSM
// states and default grid dimensions.
package grid_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_SET    = 2'd1,
        MODE_CLEAR  = 2'd2,
        MODE_NONE   = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam int DEF_ROWS = 16;
    localparam int DEF_COLS = 16;

endpackage

// File: rtl/grid_cell_editor_if.sv
// Cursor/edit bus between the user-input logic and the grid editor.
// Optional macro GRID_EDITOR_UNDO_EN adds the 'undo' pulse.
interface grid_cell_editor_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    import grid_pkg::*;

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic [ROW_W-1:0]           row_sel;
    logic [COL_W-1:0]           col_sel;
    logic                       key;
    mode_e                      mode;
    logic                       sweep_req;
    logic                       sweep_val;
`ifdef GRID_EDITOR_UNDO_EN
    logic                       undo;
`endif
    logic [ROWS-1:0][COLS-1:0]  userInput;
    logic                       cursor_cell;
    logic                       busy;
    logic                       edit_pulse;

    modport master (
`ifdef GRID_EDITOR_UNDO_EN
        output undo,
`endif
        output row_sel, col_sel, key, mode, sweep_req, sweep_val,
        input  userInput, cursor_cell, busy, edit_pulse
    );

    modport slave (
`ifdef GRID_EDITOR_UNDO_EN
        input  undo,
`endif
        input  row_sel, col_sel, key, mode, sweep_req, sweep_val,
        output userInput, cursor_cell, busy, edit_pulse
    );

endinterface

// File: rtl/grid_cell_editor_edge_rise.sv
// Rising-edge detector for an already-synchronised level input. Shared by
// the edit, step and run keys.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q_rise
);
    logic d_q;

    // Previous-cycle copy of the input, updated every cycle regardless of state
    always_ff @(posedge clk) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign q_rise = d & ~d_q;

endmodule

// File: rtl/grid_cell_editor.sv
// Grid seed editor: per-press cell edits plus a one-row-per-cycle fill/clear
// sweep. Write priority is reset > sweep > undo > edit.
// Optional macro GRID_EDITOR_UNDO_EN adds a one-deep undo of the last edit.
module grid_cell_editor
    import grid_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic               clk,
    input  logic               reset,
    grid_cell_editor_if.slave  bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    state_e                    state, state_nx;
    logic [ROWS-1:0][COLS-1:0] grid;
    logic [ROW_W-1:0]          sweep_row;
    logic                      sweep_v;
    logic                      press;
    logic                      in_range;
    logic                      cur;
    logic                      sweep_start;
    logic                      sweep_last;
    logic                      edit_pulse_q;
    logic                      undo_fire;

    logic                      row_we;
    logic [ROW_W-1:0]          row_idx;
    logic                      row_val;
    logic                      cell_we;
    logic [ROW_W-1:0]          cell_row;
    logic [COL_W-1:0]          cell_col;
    logic                      cell_val;

    edge_rise u_key_edge (
        .clk    (clk),
        .reset  (reset),
        .d      (bus.key),
        .q_rise (press)
    );

    assign in_range    = (int'(bus.row_sel) < ROWS) && (int'(bus.col_sel) < COLS);
    assign sweep_start = (state == IDLE) && bus.sweep_req;
    assign sweep_last  = (sweep_row == ROW_W'(ROWS - 1));

    // Cursor read mux; an out-of-range cursor matches no cell and reads 0
    always_comb begin
        cur = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (bus.row_sel == ROW_W'(r) && bus.col_sel == COL_W'(c))
                    cur = grid[r][c];
    end

`ifdef GRID_EDITOR_UNDO_EN
    logic             undo_valid;
    logic [ROW_W-1:0] undo_row;
    logic [COL_W-1:0] undo_col;
    logic             undo_old;

    // A sweep starting in the same cycle outranks the undo
    assign undo_fire = (state == IDLE) && !bus.sweep_req && bus.undo && undo_valid;

    // One-deep history: remember the last edited cell and its prior value
    always_ff @(posedge clk) begin
        if (reset) begin
            undo_valid <= 1'b0;
            undo_row   <= '0;
            undo_col   <= '0;
            undo_old   <= 1'b0;
        end else if (sweep_start || undo_fire) begin
            undo_valid <= 1'b0;
        end else if (cell_we && state == IDLE) begin
            undo_valid <= 1'b1;
            undo_row   <= bus.row_sel;
            undo_col   <= bus.col_sel;
            undo_old   <= cur;
        end
    end
`else
    assign undo_fire = 1'b0;
`endif

    // Write-enable and data selection, highest priority first
    always_comb begin
        row_we   = 1'b0;
        row_idx  = sweep_row;
        row_val  = sweep_v;
        cell_we  = 1'b0;
        cell_row = bus.row_sel;
        cell_col = bus.col_sel;
        cell_val = 1'b0;
        if (state == SWEEP) begin
            row_we = 1'b1;
        end
`ifdef GRID_EDITOR_UNDO_EN
        else if (undo_fire) begin
            cell_we  = 1'b1;
            cell_row = undo_row;
            cell_col = undo_col;
            cell_val = undo_old;
        end
`endif
        else if (press && !bus.sweep_req && in_range) begin
            case (bus.mode)
                MODE_TOGGLE: begin cell_we = 1'b1; cell_val = ~cur; end
                MODE_SET:    begin cell_we = 1'b1; cell_val = 1'b1; end
                MODE_CLEAR:  begin cell_we = 1'b1; cell_val = 1'b0; end
                default:     cell_we = 1'b0;
            endcase
        end
    end

    // Single point of update for the grid storage
    always_ff @(posedge clk) begin
        if (reset)        grid <= '0;
        else if (row_we)  grid[row_idx] <= {COLS{row_val}};
        else if (cell_we) grid[cell_row][cell_col] <= cell_val;
    end

    // Strobe the cycle after any single-cell write (edit or undo)
    always_ff @(posedge clk) begin
        if (reset) edit_pulse_q <= 1'b0;
        else       edit_pulse_q <= cell_we;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state: a sweep always runs to completion once started
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.sweep_req) state_nx = SWEEP;
            SWEEP:   if (sweep_last)    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Sweep row counter and latched fill value
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_row <= '0;
            sweep_v   <= 1'b0;
        end else if (sweep_start) begin
            sweep_row <= '0;
            sweep_v   <= bus.sweep_val;
        end else if (state == SWEEP) begin
            sweep_row <= sweep_last ? '0 : sweep_row + 1'b1;
        end
    end

    assign bus.userInput   = grid;
    assign bus.cursor_cell = cur;
    assign bus.busy        = (state == SWEEP);
    assign bus.edit_pulse  = edit_pulse_q;

endmodule

// File: tb/tb_grid_cell_editor.sv
// Scoreboard bench: each expected cell write pushes the expected grid into a
// queue; a monitor pops and compares on every edit_pulse. Sweep timing and
// out-of-range handling are checked directly.
module tb_grid_cell_editor;
    import grid_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   tests = 0;
    int   fails = 0;

    grid_cell_editor_if #(.ROWS(16), .COLS(16)) ia ();
    grid_cell_editor_if #(.ROWS(10), .COLS(12)) ib ();

    grid_cell_editor #(.ROWS(16), .COLS(16)) dut_a (.clk(clk), .reset(rst_a), .bus(ia.slave));
    grid_cell_editor #(.ROWS(10), .COLS(12)) dut_b (.clk(clk), .reset(rst_b), .bus(ib.slave));

    logic [255:0]       qa [$];
    logic [255:0]       qb [$];
    logic [15:0][15:0]  ma;
    logic [9:0][11:0]   mb;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every edit_pulse must match the next queued expectation
    always @(negedge clk) begin
        if (!rst_a && ia.edit_pulse) begin
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL edit_a_unexpected: edit_pulse=1 with no write expected, grid %0h", ia.userInput);
            end else chk("edit_a_grid", 256'(ia.userInput), qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst_b && ib.edit_pulse) begin
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL edit_b_unexpected: edit_pulse=1 with no write expected, grid %0h", ib.userInput);
            end else chk("edit_b_grid", 256'(ib.userInput), qb.pop_front());
        end
    end

    // One key press on grid A with the model updated by hand-derived rules
    task automatic press_a(input int r, input int c, input mode_e m);
        ia.row_sel = 4'(r);
        ia.col_sel = 4'(c);
        ia.mode    = m;
        if (m != MODE_NONE) begin
            case (m)
                MODE_TOGGLE: ma[r][c] = ~ma[r][c];
                MODE_SET:    ma[r][c] = 1'b1;
                default:     ma[r][c] = 1'b0;
            endcase
            qa.push_back(256'(ma));
        end
        ia.key = 1'b1;
        step();
        ia.key = 1'b0;
        step();
        step();
    endtask

    // Sweep grid A; checks fill order every cycle, optional mid-sweep press/reset
    task automatic sweep_a(input logic val, input int press_at, input int reset_at, output int cnt);
        logic [15:0][15:0] base;
        logic [15:0][15:0] e;
        base = ma;
        ia.sweep_val = val;
        ia.sweep_req = 1'b1;
        step();
        ia.sweep_req = 1'b0;
        cnt = 0;
        while (ia.busy && cnt < 40) begin
            e = base;
            for (int j = 0; j < cnt; j++) e[j] = {16{val}};
            chk("sweep_a_row_order", 256'(ia.userInput), 256'(e));
            if (cnt == reset_at) begin
                rst_a = 1'b1;
                step();
                rst_a = 1'b0;
                chk("reset_mid_sweep_grid", 256'(ia.userInput), 256'(0));
                chk("reset_mid_sweep_busy", 256'(ia.busy), 256'(0));
                ma = '0;
                return;
            end
            if (press_at >= 0 && cnt == press_at)     ia.key = 1'b1;
            if (press_at >= 0 && cnt == press_at + 2) ia.key = 1'b0;
            step();
            cnt++;
        end
        ia.key = 1'b0;
        for (int r = 0; r < 16; r++) ma[r] = {16{val}};
    endtask

    initial begin
        int n;
        ma = '0; mb = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        ia.row_sel = '0; ia.col_sel = '0; ia.key = 1'b0; ia.mode = MODE_TOGGLE;
        ia.sweep_req = 1'b0; ia.sweep_val = 1'b0;
        ib.row_sel = '0; ib.col_sel = '0; ib.key = 1'b0; ib.mode = MODE_TOGGLE;
        ib.sweep_req = 1'b0; ib.sweep_val = 1'b0;
`ifdef GRID_EDITOR_UNDO_EN
        ia.undo = 1'b0; ib.undo = 1'b0;
`endif
        repeat (3) step();
        chk("reset_grid_a", 256'(ia.userInput), 256'(0));
        chk("reset_busy_a", 256'(ia.busy), 256'(0));
        chk("reset_pulse_a", 256'(ia.edit_pulse), 256'(0));
        chk("reset_grid_b", 256'(ib.userInput), 256'(0));
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // Held key: exactly one toggle of [3][5]
        ia.row_sel = 4'd3; ia.col_sel = 4'd5; ia.mode = MODE_TOGGLE;
        ma[3][5] = 1'b1;
        qa.push_back(256'(ma));
        ia.key = 1'b1;
        repeat (10) step();
        chk("hold_cell_35", 256'(ia.userInput[3][5]), 256'(1));
        chk("hold_cursor", 256'(ia.cursor_cell), 256'(1));
        ia.key = 1'b0;
        step();

        // Mode sweep on the same cell
        press_a(3, 5, MODE_TOGGLE);
        press_a(3, 5, MODE_SET);
        press_a(3, 5, MODE_SET);
        chk("set_cursor", 256'(ia.cursor_cell), 256'(1));
        press_a(3, 5, MODE_CLEAR);
        press_a(3, 5, MODE_NONE);
        chk("none_no_change", 256'(ia.userInput), 256'(ma));
        press_a(15, 0, MODE_SET);
        press_a(0, 15, MODE_SET);

        // Fill sweep with a press mid-way that must leave no trace
        sweep_a(1'b1, 5, -1, n);
        chk("sweep_fill_cycles", 256'(n), 256'(16));
        step(); step();
        chk("sweep_fill_grid", 256'(ia.userInput), {256{1'b1}});

        // Press coinciding with sweep_req: sweep wins
        ia.row_sel = 4'd1; ia.col_sel = 4'd1; ia.mode = MODE_TOGGLE;
        ia.key = 1'b1;
        sweep_a(1'b0, -1, -1, n);
        chk("sweep_clear_cycles", 256'(n), 256'(16));
        step(); step();
        chk("sweep_clear_grid", 256'(ia.userInput), 256'(0));

        // Reset while filling, at row 7
        sweep_a(1'b1, -1, 7, n);
        step();
        press_a(4, 4, MODE_SET);

        // Grid B: 10 x 12, out-of-range cursor and short sweep
        ib.row_sel = 4'd12; ib.col_sel = 4'd3; ib.mode = MODE_TOGGLE;
        ib.key = 1'b1;
        step();
        chk("b_cursor_oor", 256'(ib.cursor_cell), 256'(0));
        ib.key = 1'b0;
        step(); step();
        chk("b_row_oor_nochange", 256'(ib.userInput), 256'(0));
        ib.row_sel = 4'd2; ib.col_sel = 4'd13; ib.key = 1'b1;
        step(); ib.key = 1'b0; step(); step();
        chk("b_col_oor_nochange", 256'(ib.userInput), 256'(0));
        ib.row_sel = 4'd9; ib.col_sel = 4'd11;
        mb[9][11] = 1'b1;
        qb.push_back(256'(mb));
        ib.key = 1'b1; step(); ib.key = 1'b0; step(); step();
        chk("b_cursor_corner", 256'(ib.cursor_cell), 256'(1));
        ib.sweep_val = 1'b1; ib.sweep_req = 1'b1;
        step();
        ib.sweep_req = 1'b0;
        n = 0;
        while (ib.busy && n < 40) begin step(); n++; end
        chk("b_sweep_cycles", 256'(n), 256'(10));
        chk("b_sweep_grid", 256'(ib.userInput), {136'd0, {120{1'b1}}});

`ifdef GRID_EDITOR_UNDO_EN
        // Undo restores the last edit once, and never after a sweep
        rst_a = 1'b1; step(); rst_a = 1'b0; step();
        ma = '0;
        press_a(2, 2, MODE_TOGGLE);
        ma[2][2] = 1'b0;
        qa.push_back(256'(ma));
        ia.undo = 1'b1; step(); ia.undo = 1'b0; step(); step();
        chk("undo_restore", 256'(ia.userInput[2][2]), 256'(0));
        ia.undo = 1'b1; step(); ia.undo = 1'b0; step(); step();
        chk("undo_second_ignored", 256'(ia.userInput), 256'(ma));
        press_a(2, 2, MODE_TOGGLE);
        sweep_a(1'b0, -1, -1, n);
        ia.undo = 1'b1; step(); ia.undo = 1'b0; step(); step();
        chk("undo_after_sweep", 256'(ia.userInput), 256'(0));
`endif

        repeat (3) step();
        chk("queue_a_drained", 256'(qa.size()), 256'(0));
        chk("queue_b_drained", 256'(qb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
